// File: rtl/cv_term_drv_if.sv
// Word/result handshake bundle between an upstream source, cv_term_drv and the result consumer.
// Both channels are valid/ready: a transfer happens on a rising edge where valid && ready, and the sender holds its payload steady until then.
interface cv_term_drv_if #(
    parameter int NLANE = 2
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*NLANE-1:0]   in_data;
    logic                 res_valid;
    logic                 res_ready;
    logic [NLANE-1:0]     res_data;
    logic [NLANE-1:0]     res_err;

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_err
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_err
    );
endinterface

// File: rtl/cv_term_drv.sv
// Drives a 2-bit word onto each cv_bus_term lane, waits HOLD_CYC edges, then samples the lanes
// and checks each one against the NOR of the bits it was driven with.
module cv_term_drv #(
    parameter int NLANE    = 2,
    parameter int HOLD_CYC = 4
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               VDD,
    input  logic               VSS,
    cv_term_drv_if.slave       bus,
    output logic [2*NLANE-1:0] drv_out,
    input  logic [NLANE-1:0]   term_out,
    output logic [7:0]         err_cnt,
    input  logic               err_clr,
    output logic [0:0]         dbg_state,
    output logic [7:0]         dbg_cnt
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SETTLE = 1'b1;
    localparam logic [7:0] HOLD   = 8'(HOLD_CYC);

    logic [0:0]       state;
    logic [7:0]       cnt;
    logic             res_valid_q;
    logic [NLANE-1:0] res_data_q;
    logic [NLANE-1:0] res_err_q;
    logic [NLANE-1:0] expected;
    logic [NLANE-1:0] res_err_next;
    logic             accept;
    logic             capture;
    logic             pop;
    logic             unused_pwr;

    // Supply pins exist only so the netlist carries them through.
    assign unused_pwr = VDD ^ VSS;

    always_comb begin
        expected = '0;
        for (int i = 0; i < NLANE; i++) begin
            expected[i] = ~(drv_out[2*i+1] | drv_out[2*i]);
        end
    end

    assign res_err_next  = term_out ^ expected;
    assign bus.in_ready  = (state == IDLE) && !res_valid_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign capture       = (state == SETTLE) && (cnt == HOLD);
    assign pop           = res_valid_q && bus.res_ready;

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign dbg_state     = state;
    assign dbg_cnt       = cnt;

    // cnt counts edges since accept, so the HOLD_CYC-th edge is the sample edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= SETTLE;
                        cnt   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (capture) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            drv_out <= '0;
        end else if (accept) begin
            drv_out <= bus.in_data;
        end
    end

    // A capture can never coincide with a pop: capture needs SETTLE, which needs res_valid low at accept.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= '0;
        end else if (capture) begin
            res_valid_q <= 1'b1;
            res_data_q  <= term_out;
            res_err_q   <= res_err_next;
        end else if (pop) begin
            res_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            err_cnt <= 8'd0;
        end else if (err_clr) begin
            err_cnt <= 8'd0;
        end else if (capture && (|res_err_next) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_cv_term_drv.sv
// Directed bench for cv_term_drv: NLANE=2 with HOLD_CYC=4, plus a HOLD_CYC=1 instance for the minimum settle.
module tb_cv_term_drv;
    localparam int NLANE = 2;
    localparam int HOLD  = 4;
    localparam int W     = 2 * NLANE;

    logic             clk = 1'b0;
    logic             rstb = 1'b0;
    logic [W-1:0]     drv_out, drv_out1;
    logic [NLANE-1:0] term_out, term_out1;
    logic [7:0]       err_cnt, err_cnt1;
    logic             err_clr, err_clr1;
    logic [0:0]       dbg_state, dbg_state1;
    logic [7:0]       dbg_cnt, dbg_cnt1;

    int n_checks = 0;
    int n_fail   = 0;
    int model_err_cnt = 0;
    logic [W-1:0] exp_q[$];

    cv_term_drv_if #(.NLANE(NLANE)) bus ();
    cv_term_drv_if #(.NLANE(NLANE)) bus1 ();

    cv_term_drv #(.NLANE(NLANE), .HOLD_CYC(HOLD)) u_dut (
        .clk(clk), .rstb(rstb), .VDD(1'b1), .VSS(1'b0), .bus(bus),
        .drv_out(drv_out), .term_out(term_out), .err_cnt(err_cnt), .err_clr(err_clr),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    cv_term_drv #(.NLANE(NLANE), .HOLD_CYC(1)) u_dut1 (
        .clk(clk), .rstb(rstb), .VDD(1'b1), .VSS(1'b0), .bus(bus1),
        .drv_out(drv_out1), .term_out(term_out1), .err_cnt(err_cnt1), .err_clr(err_clr1),
        .dbg_state(dbg_state1), .dbg_cnt(dbg_cnt1)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NLANE-1:0] nor_exp(input logic [W-1:0] w);
        logic [NLANE-1:0] r;
        for (int i = 0; i < NLANE; i++) r[i] = ~(w[2*i+1] | w[2*i]);
        return r;
    endfunction

    // Apply one word, randomise term_out except at the sample edge, then check the captured result.
    task automatic run_word(input logic [W-1:0] word, input logic [NLANE-1:0] term,
                            input bit clr_at_sample, input bit detail);
        logic [NLANE-1:0] e_err;
        logic [W-1:0]     e;
        int n;
        e_err = term ^ nor_exp(word);
        exp_q.push_back({e_err, term});
        if (clr_at_sample) model_err_cnt = 0;
        else if (e_err != 0 && model_err_cnt < 255) model_err_cnt++;

        bus.in_valid = 1'b1;
        bus.in_data  = word;
        term_out     = NLANE'($urandom_range(0, 3));
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
        if (detail) begin
            check("drv_out_on_accept", drv_out, word);
            check("in_ready_in_settle", bus.in_ready, 0);
        end
        n = 0;
        while (!bus.res_valid && n < HOLD + 4) begin
            if (n == HOLD - 1) begin
                term_out = term;
                err_clr  = clr_at_sample;
            end else begin
                term_out = NLANE'($urandom_range(0, 3));
            end
            tick();
            err_clr = 1'b0;
            n++;
        end
        check("result_arrived", bus.res_valid, 1);
        if (detail) check("sample_latency", n, HOLD);
        e = exp_q.pop_front();
        check("res_err", bus.res_err, e[W-1:NLANE]);
        check("res_data", bus.res_data, e[NLANE-1:0]);
        check("err_cnt", err_cnt, model_err_cnt);
    endtask

    task automatic pop_result();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("res_valid_after_pop", bus.res_valid, 0);
        check("in_ready_after_pop", bus.in_ready, 1);
    endtask

    initial begin
        bit stable;
        bit seen;
        int n;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.res_ready = 1'b0;
        term_out = '0; term_out1 = '0; err_clr = 1'b0; err_clr1 = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_drv_out", drv_out, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_state", dbg_state, 0);
        rstb = 1'b1;
        tick();
        check("in_ready_after_rst", bus.in_ready, 1);

        // Correct NOR lanes: 0100 -> expect 01, no error; drv_out holds after the pop
        run_word(4'b0100, 2'b01, 1'b0, 1'b1);
        pop_result();
        check("drv_out_holds", drv_out, 4'b0100);

        // term_out=11 against expected 01 -> res_err=10, err_cnt=1
        run_word(4'b0100, 2'b11, 1'b0, 1'b1);
        pop_result();
        run_word(4'b1011, 2'b00, 1'b0, 1'b1);
        pop_result();
        run_word(4'b0000, 2'b11, 1'b0, 1'b1);
        pop_result();
        run_word(4'b1111, 2'b01, 1'b0, 1'b1);
        pop_result();

        // Saturation at 255
        for (int i = 0; i < 300; i++) begin
            run_word(4'b0100, 2'b11, 1'b0, 1'b0);
            pop_result();
        end
        check("err_cnt_saturated", err_cnt, 8'd255);

        // Clear while idle, then clear colliding with an error capture
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        model_err_cnt = 0;
        check("err_clr_idle", err_cnt, 0);
        run_word(4'b0100, 2'b11, 1'b0, 1'b1);
        pop_result();
        run_word(4'b0100, 2'b11, 1'b1, 1'b1);
        check("clr_wins_res_err", bus.res_err, 2'b10);
        pop_result();

        // Back-pressure: result held, new words ignored, no accept on the pop edge
        run_word(4'b0000, 2'b11, 1'b0, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1010;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            term_out = NLANE'($urandom_range(0, 3));
            tick();
            if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_data !== 2'b11 ||
                bus.res_err !== 2'b00 || drv_out !== 4'b0000) stable = 1'b0;
        end
        check("backpressure_stable", stable, 1);
        term_out = 2'b00;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check("bp_pop_res_valid", bus.res_valid, 0);
        check("bp_pop_no_accept", drv_out, 4'b0000);
        check("bp_pop_state", dbg_state, 0);
        check("bp_in_ready_next", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_accept_drv", drv_out, 4'b1010);
        check("bp_accept_state", dbg_state, 1);
        n = 0;
        while (!bus.res_valid && n < HOLD + 4) begin
            tick();
            n++;
        end
        check("bp_latency", n, HOLD);
        check("bp_res_data", bus.res_data, 2'b00);
        check("bp_res_err", bus.res_err, 2'b00);
        pop_result();

        // Reset in the middle of SETTLE
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0100;
        term_out     = 2'b11;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("mid_settle_cnt", dbg_cnt, 2);
        #2 rstb = 1'b0;
        #1;
        check("abort_drv_out", drv_out, 0);
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_res_valid", bus.res_valid, 0);
        check("abort_err_cnt", err_cnt, 0);
        check("abort_state", dbg_state, 0);
        check("abort_cnt", dbg_cnt, 0);
        repeat (2) tick();
        rstb = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.res_valid !== 1'b0) seen = 1'b1;
        end
        check("abort_no_result", seen, 0);
        check("abort_err_cnt_after", err_cnt, 0);

        // HOLD_CYC=1: sample on the edge right after accept; 0001 -> expected NOR 10
        bus1.in_valid = 1'b1;
        bus1.in_data  = 4'b0001;
        term_out1     = 2'b10;
        tick();
        bus1.in_valid = 1'b0;
        check("h1_drv_out", drv_out1, 4'b0001);
        check("h1_no_result_yet", bus1.res_valid, 0);
        tick();
        check("h1_res_valid", bus1.res_valid, 1);
        check("h1_res_data", bus1.res_data, 2'b10);
        check("h1_res_err", bus1.res_err, 2'b00);
        check("h1_err_cnt", err_cnt1, 0);
        bus1.res_ready = 1'b1;
        tick();
        bus1.res_ready = 1'b0;
        check("h1_pop", bus1.res_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
